// File: rtl/wb_slave_mem.sv
// wb_slave_mem: Wishbone B4 classic-cycle slave backed by a DATA_WIDTH-wide word
// memory, with programmable wait states, ERR on out-of-range index or empty
// SEL_I, and deterministic RTY on every RETRY_PERIOD-th non-ERR transfer.
// Optional feature: define WB_SLAVE_MEM_TAG_EN to add a per-word tag array
// exchanged on TGD_I/TGD_O; otherwise TGD_I is ignored and TGD_O is 0.
module wb_slave_mem #(
  parameter int DATA_WIDTH   = 64,
  parameter int ADDR_WIDTH   = 64,
  parameter int DEPTH        = 1024,
  parameter int WAIT_STATES  = 0,
  parameter int RETRY_PERIOD = 0,
  parameter int TAG_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    CYC_I,
  input  logic                    STB_I,
  input  logic                    WE_I,
  input  logic [ADDR_WIDTH-1:0]   ADR_I,
  input  logic [DATA_WIDTH/8-1:0] SEL_I,
  input  logic [DATA_WIDTH-1:0]   DAT_I,
  output logic [DATA_WIDTH-1:0]   DAT_O,
  input  logic [TAG_WIDTH-1:0]    TGD_I,
  output logic [TAG_WIDTH-1:0]    TGD_O,
  output logic                    ACK_O,
  output logic                    ERR_O,
  output logic                    RTY_O
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int SHIFT = (NB > 1) ? $clog2(NB) : 0;
  localparam int MAW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RCW   = (RETRY_PERIOD > 0) ? $clog2(RETRY_PERIOD + 1) : 1;

  localparam logic [RCW-1:0]      RC_LAST   = (RETRY_PERIOD > 0) ? RCW'(RETRY_PERIOD - 1) : '0;
  localparam logic [7:0]          WAIT_LOAD = (WAIT_STATES > 0) ? 8'(WAIT_STATES - 1) : 8'd0;
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  logic                  req;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [NB-1:0]         sel_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [7:0]            wcnt;
  logic [RCW-1:0]        rcnt;
  logic [ADDR_WIDTH-1:0] idx;
  logic [MAW-1:0]        midx;
  logic                  is_err;
  logic                  is_rty;
  logic                  is_ack;
  logic                  resp_fire;
  logic                  mem_wr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign req       = CYC_I & STB_I;
  assign idx       = adr_q >> SHIFT;
  assign midx      = idx[MAW-1:0];
  assign resp_fire = (state == S_RESP);

  // Termination decode on the captured request; ERR outranks RTY, RTY outranks ACK
  always_comb begin
    is_err = ({1'b0, idx} >= DEPTH_LIM) || (sel_q == '0);
    is_rty = (RETRY_PERIOD > 0) && (rcnt == RC_LAST) && !is_err;
    is_ack = !is_err && !is_rty;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; RESP always returns to IDLE, WAIT aborts when the request drops
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
        end
      end
      S_WAIT: begin
        if (!req) begin
          state_nxt = S_IDLE;
        end else if (wcnt == '0) begin
          state_nxt = S_RESP;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Wait-state countdown, loaded when a request is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt <= '0;
    end else if (state == S_IDLE && req) begin
      wcnt <= WAIT_LOAD;
    end else if (state == S_WAIT && wcnt != '0) begin
      wcnt <= wcnt - 8'd1;
    end
  end

  // Request capture; only meaningful while a transfer is in flight
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      we_q  <= WE_I;
      adr_q <= ADR_I;
      sel_q <= SEL_I;
      dat_q <= DAT_I;
    end
  end

  // Registered terminations, read data and retry counter, updated on leaving RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      RTY_O <= 1'b0;
      DAT_O <= '0;
      rcnt  <= '0;
    end else begin
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      RTY_O <= 1'b0;
      if (resp_fire) begin
        ACK_O <= is_ack;
        ERR_O <= is_err;
        RTY_O <= is_rty;
        if (!is_err && (RETRY_PERIOD > 0)) begin
          rcnt <= is_rty ? '0 : rcnt + 1'b1;
        end
        if (!we_q) begin
          DAT_O <= is_ack ? mem[midx] : '0;
        end
      end
    end
  end

  // Byte-lane write on an ACKed write; rst in the same cycle discards it
  assign mem_wr = resp_fire && we_q && is_ack && !rst;

  // Memory write port
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (sel_q[b]) begin
          mem[midx][8*b +: 8] <= dat_q[8*b +: 8];
        end
      end
    end
  end

`ifdef WB_SLAVE_MEM_TAG_EN
  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
  logic [TAG_WIDTH-1:0] tgd_q;

  // Tag capture alongside the data request
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      tgd_q <= TGD_I;
    end
  end

  // Tag store on ACKed writes, independent of SEL_I
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      tag_mem[midx] <= tgd_q;
    end
  end

  // Tag readback with DAT_O timing; ERR/RTY force 0
  always_ff @(posedge clk) begin
    if (rst) begin
      TGD_O <= '0;
    end else if (resp_fire) begin
      if (!is_ack) begin
        TGD_O <= '0;
      end else if (!we_q) begin
        TGD_O <= tag_mem[midx];
      end
    end
  end
`else
  logic unused_tgd;
  assign unused_tgd = ^TGD_I;
  assign TGD_O      = '0;
`endif

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed bench for wb_slave_mem: three instances cover the plain slave
// (no waits, no retry), RETRY_PERIOD=3 and WAIT_STATES=4.
module tb_wb_slave_mem;

  localparam int DW = 64;
  localparam int AW = 64;
  localparam int TW = 16;
  localparam int NB = 8;
  localparam int NI = 3;

  localparam logic [2:0] R_ACK = 3'b100;
  localparam logic [2:0] R_ERR = 3'b010;
  localparam logic [2:0] R_RTY = 3'b001;

  logic          clk;
  logic          rst;
  logic          cyc   [NI];
  logic          stb   [NI];
  logic          we    [NI];
  logic [AW-1:0] adr   [NI];
  logic [NB-1:0] sel   [NI];
  logic [DW-1:0] dat_w [NI];
  logic [DW-1:0] dat_r [NI];
  logic [TW-1:0] tgd_w [NI];
  logic [TW-1:0] tgd_r [NI];
  logic          ack   [NI];
  logic          err   [NI];
  logic          rty   [NI];

  int checks = 0;
  int errors = 0;
  int vec_no = 0;

  typedef struct {
    int          inst;
    logic        w;
    logic [63:0] a;
    logic [7:0]  s;
    logic [63:0] d;
    logic [2:0]  er;
    logic [63:0] ed;
  } vec_t;

  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024), .WAIT_STATES(0),
                 .RETRY_PERIOD(0), .TAG_WIDTH(TW)) u_plain (
    .clk(clk), .rst(rst), .CYC_I(cyc[0]), .STB_I(stb[0]), .WE_I(we[0]), .ADR_I(adr[0]),
    .SEL_I(sel[0]), .DAT_I(dat_w[0]), .DAT_O(dat_r[0]), .TGD_I(tgd_w[0]), .TGD_O(tgd_r[0]),
    .ACK_O(ack[0]), .ERR_O(err[0]), .RTY_O(rty[0]));

  wb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024), .WAIT_STATES(0),
                 .RETRY_PERIOD(3), .TAG_WIDTH(TW)) u_retry (
    .clk(clk), .rst(rst), .CYC_I(cyc[1]), .STB_I(stb[1]), .WE_I(we[1]), .ADR_I(adr[1]),
    .SEL_I(sel[1]), .DAT_I(dat_w[1]), .DAT_O(dat_r[1]), .TGD_I(tgd_w[1]), .TGD_O(tgd_r[1]),
    .ACK_O(ack[1]), .ERR_O(err[1]), .RTY_O(rty[1]));

  wb_slave_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(1024), .WAIT_STATES(4),
                 .RETRY_PERIOD(0), .TAG_WIDTH(TW)) u_wait (
    .clk(clk), .rst(rst), .CYC_I(cyc[2]), .STB_I(stb[2]), .WE_I(we[2]), .ADR_I(adr[2]),
    .SEL_I(sel[2]), .DAT_I(dat_w[2]), .DAT_O(dat_r[2]), .TGD_I(tgd_w[2]), .TGD_O(tgd_r[2]),
    .ACK_O(ack[2]), .ERR_O(err[2]), .RTY_O(rty[2]));

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int i, input logic w, input logic [63:0] a,
                               input logic [7:0] s, input logic [63:0] d,
                               input logic [2:0] er, input logic [63:0] ed);
    vec_t v;
    v.inst = i; v.w = w; v.a = a; v.s = s; v.d = d; v.er = er; v.ed = ed;
    return v;
  endfunction

  // Starts and ends on a falling edge; drops the request as soon as a termination is seen
  task automatic xfer(input int i, input logic w, input logic [63:0] a, input logic [7:0] s,
                      input logic [63:0] d, input logic [15:0] t, input logic [2:0] er,
                      input logic [63:0] ed, input string nm);
    int n;
    int lat;
    logic [2:0] got;
    lat = (i == 2) ? 6 : 2;
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; sel[i] = s; dat_w[i] = d; tgd_w[i] = t;
    n = 0;
    got = '0;
    while (got == 3'b000 && n < 40) begin
      @(negedge clk);
      n++;
      got = {ack[i], err[i], rty[i]};
    end
    cyc[i] = 1'b0; stb[i] = 1'b0;
    check({nm, " resp"}, 64'(got), 64'(er));
    check({nm, " latency"}, 64'(n), 64'(lat));
    if (!w) check({nm, " dat"}, dat_r[i], ed);
    @(negedge clk);
    check({nm, " pulse_end"}, 64'({ack[i], err[i], rty[i]}), 64'(0));
  endtask

  task automatic run_tbl();
    for (int k = 0; k < tbl.size(); k++) begin
      xfer(tbl[k].inst, tbl[k].w, tbl[k].a, tbl[k].s, tbl[k].d, 16'h0, tbl[k].er, tbl[k].ed,
           $sformatf("vec%0d_i%0d", vec_no, tbl[k].inst));
      vec_no++;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] seen;
    logic [15:0] exp_tag;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0; adr[i] = '0;
      sel[i] = '0; dat_w[i] = '0; tgd_w[i] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values held while idle
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        check($sformatf("idle%0d_i%0d term", c, i), 64'({ack[i], err[i], rty[i]}), 64'(0));
        check($sformatf("idle%0d_i%0d dat", c, i), dat_r[i], 64'h0);
        check($sformatf("idle%0d_i%0d tgd", c, i), 64'(tgd_r[i]), 64'h0);
      end
    end

    // Plain slave: full/partial writes, range errors, empty SEL, misaligned, last word
    tbl.push_back(mkv(0, 1, 64'h10,   8'hFF, 64'h1122334455667788, R_ACK, 64'h0));
    tbl.push_back(mkv(0, 0, 64'h10,   8'hFF, 64'h0,                R_ACK, 64'h1122334455667788));
    tbl.push_back(mkv(0, 1, 64'h10,   8'h0F, 64'hAAAAAAAAAAAAAAAA, R_ACK, 64'h0));
    tbl.push_back(mkv(0, 0, 64'h10,   8'hFF, 64'h0,                R_ACK, 64'h11223344AAAAAAAA));
    tbl.push_back(mkv(0, 1, 64'h0,    8'hFF, 64'h0123456789ABCDEF, R_ACK, 64'h0));
    tbl.push_back(mkv(0, 0, 64'h2000, 8'hFF, 64'h0,                R_ERR, 64'h0));
    tbl.push_back(mkv(0, 1, 64'h2000, 8'hFF, 64'hDEADBEEFDEADBEEF, R_ERR, 64'h0));
    tbl.push_back(mkv(0, 0, 64'h0,    8'hFF, 64'h0,                R_ACK, 64'h0123456789ABCDEF));
    tbl.push_back(mkv(0, 0, 64'h13,   8'h01, 64'h0,                R_ACK, 64'h11223344AAAAAAAA));
    tbl.push_back(mkv(0, 1, 64'h18,   8'h00, 64'h5A5A5A5A5A5A5A5A, R_ERR, 64'h0));
    tbl.push_back(mkv(0, 0, 64'h18,   8'h00, 64'h0,                R_ERR, 64'h0));
    tbl.push_back(mkv(0, 1, 64'h1FF8, 8'hFF, 64'hCAFEF00D12345678, R_ACK, 64'h0));
    tbl.push_back(mkv(0, 0, 64'h1FF8, 8'hFF, 64'h0,                R_ACK, 64'hCAFEF00D12345678));
    tbl.push_back(mkv(0, 1, 64'h8,    8'hFF, 64'h0,                R_ACK, 64'h0));
    tbl.push_back(mkv(0, 1, 64'h8,    8'h81, 64'hFFFFFFFFFFFFFFFF, R_ACK, 64'h0));
    tbl.push_back(mkv(0, 0, 64'h8,    8'hFF, 64'h0,                R_ACK, 64'hFF000000000000FF));
    // Retry instance: counter advances on writes and reads, not on ERR
    tbl.push_back(mkv(1, 1, 64'h0,    8'hFF, 64'h5555AAAA5555AAAA, R_ACK, 64'h0));
    tbl.push_back(mkv(1, 0, 64'h0,    8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    tbl.push_back(mkv(1, 0, 64'h0,    8'hFF, 64'h0,                R_RTY, 64'h0));
    tbl.push_back(mkv(1, 0, 64'h0,    8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    tbl.push_back(mkv(1, 0, 64'h0,    8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    tbl.push_back(mkv(1, 0, 64'h0,    8'hFF, 64'h0,                R_RTY, 64'h0));
    tbl.push_back(mkv(1, 0, 64'h0,    8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    tbl.push_back(mkv(1, 0, 64'h0,    8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    tbl.push_back(mkv(1, 0, 64'h0,    8'hFF, 64'h0,                R_RTY, 64'h0));
    tbl.push_back(mkv(1, 0, 64'h2000, 8'hFF, 64'h0,                R_ERR, 64'h0));
    tbl.push_back(mkv(1, 0, 64'h0,    8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    tbl.push_back(mkv(1, 0, 64'h0,    8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    tbl.push_back(mkv(1, 0, 64'h0,    8'hFF, 64'h0,                R_RTY, 64'h0));
    tbl.push_back(mkv(1, 0, 64'h0,    8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    // Wait-state instance: latency 2+4
    tbl.push_back(mkv(2, 1, 64'h20,   8'hFF, 64'h0F0E0D0C0B0A0908, R_ACK, 64'h0));
    tbl.push_back(mkv(2, 0, 64'h20,   8'hFF, 64'h0,                R_ACK, 64'h0F0E0D0C0B0A0908));
    run_tbl();

    // Reset with retry counter at 1: counter restarts, DAT_O cleared
    pulse_rst();
    check("rty_rst dat", dat_r[1], 64'h0);
    tbl.delete();
    tbl.push_back(mkv(1, 0, 64'h0, 8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    tbl.push_back(mkv(1, 0, 64'h0, 8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    tbl.push_back(mkv(1, 0, 64'h0, 8'hFF, 64'h0,                R_RTY, 64'h0));
    tbl.push_back(mkv(1, 0, 64'h0, 8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    tbl.push_back(mkv(1, 0, 64'h0, 8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    tbl.push_back(mkv(1, 1, 64'h0, 8'hFF, 64'h1111111111111111, R_RTY, 64'h0));
    tbl.push_back(mkv(1, 0, 64'h0, 8'hFF, 64'h0,                R_ACK, 64'h5555AAAA5555AAAA));
    run_tbl();

    // Abort: CYC_I drops two cycles into the wait period
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 64'h20; sel[2] = 8'hFF;
    dat_w[2] = 64'hFFFFFFFFFFFFFFFF;
    seen = '0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | {ack[2], err[2], rty[2]};
    end
    cyc[2] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen = seen | {ack[2], err[2], rty[2]};
    end
    stb[2] = 1'b0;
    check("abort no_term", 64'(seen), 64'(0));
    xfer(2, 0, 64'h20, 8'hFF, 64'h0, 16'h0, R_ACK, 64'h0F0E0D0C0B0A0908, "abort_readback");

    // Reset while in RESP: write is discarded and no termination appears
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 64'h20; sel[2] = 8'hFF;
    dat_w[2] = 64'h7777777777777777;
    seen = '0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | {ack[2], err[2], rty[2]};
    end
    cyc[2] = 1'b0; stb[2] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    seen = seen | {ack[2], err[2], rty[2]};
    check("midrst dat", dat_r[2], 64'h0);
    @(negedge clk);
    rst = 1'b0;
    seen = seen | {ack[2], err[2], rty[2]};
    check("midrst no_term", 64'(seen), 64'(0));
    xfer(2, 0, 64'h20, 8'hFF, 64'h0, 16'h0, R_ACK, 64'h0F0E0D0C0B0A0908, "midrst_readback");

    // Tag path
`ifdef WB_SLAVE_MEM_TAG_EN
    exp_tag = 16'hBEEF;
`else
    exp_tag = 16'h0000;
`endif
    xfer(0, 1, 64'h30, 8'hFF, 64'h0102030405060708, 16'hBEEF, R_ACK, 64'h0, "tag_wr");
    xfer(0, 0, 64'h30, 8'hFF, 64'h0, 16'h0, R_ACK, 64'h0102030405060708, "tag_rd");
    check("tag_rd tgd", 64'(tgd_r[0]), 64'(exp_tag));
    xfer(0, 0, 64'h2000, 8'hFF, 64'h0, 16'h0, R_ERR, 64'h0, "tag_err");
    check("tag_err tgd", 64'(tgd_r[0]), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
